fetch_queue: RTL and testbench

Instruction prefetch buffer sitting between the instruction memory and the decoder, feeding the decoder's 32-bit instruction input.
- Issues sequential 16-bit word reads to instruction memory and buffers the returned words in a circular queue.
- Assembles 16-bit or 32-bit AAP instructions at the queue head and hands them to the decoder with a valid/ready handshake.
- On a flush, discards all buffered and in-flight words and restarts fetching at a redirect address supplied by execute.

---
 rtl/fetch_queue.sv | 142 ++++++++++++++
 tb/tb_fetch_queue.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential 16-bit fetch, circular buffer, 16/32-bit AAP assembly.
// Optional combinational forwarding of the arriving word is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int          DEPTH    = 8,
  parameter logic [19:0] RESET_PC = 20'h00000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     stop,
  input  logic                     flush,
  input  logic [19:0]              flush_pc,
  output logic [19:0]              imem_addr,
  output logic                     imem_req,
  input  logic [15:0]              imem_data,
  output logic [31:0]              instr,
  output logic [19:0]              instr_pc,
  output logic                     instr_long,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   occupancy
);

  // Handshake: an instruction transfers on any cycle where instr_valid & instr_ready are both
  // high (and flush is low); while instr_valid is high and instr_ready low, instr* stay stable.

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_n, rd1_n, wr_n;
  logic [OW-1:0] occ, occ_n, used, q_pop;
  logic [19:0]   fetch_pc, head_pc, head_pc_n;
  logic          inflight, kill, push, push_eff, pop, byp_pop;
  logic [1:0]    pop_len;
  logic [15:0]   w0_n, w1_n;
  logic          valid_n;
  logic [31:0]   instr_q;
  logic [19:0]   pc_q;
  logic          long_q, valid_q;

  // Full check counts the outstanding read so the queue can never overflow.
  assign used      = occ + OW'(inflight);
  assign imem_req  = reset & ~stop & ~flush & (used < OW'(DEPTH));
  assign imem_addr = fetch_pc;
  assign occupancy = occ;
  assign push      = inflight & ~kill & ~flush;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic [15:0] head0;
  logic        byp_active, byp_valid, byp_long;
  logic [31:0] byp_instr;

  // Forward the returning word when it completes the head instruction.
  always_comb begin
    head0      = mem[rd_ptr];
    byp_active = push & ((occ == '0) | ((occ == OW'(1)) & head0[15]));
    if (occ == '0) begin
      byp_instr = {16'h0000, imem_data};
      byp_long  = 1'b0;
      byp_valid = ~imem_data[15];
    end else begin
      byp_instr = {imem_data, head0};
      byp_long  = 1'b1;
      byp_valid = 1'b1;
    end
  end

  assign instr       = byp_active ? byp_instr : instr_q;
  assign instr_long  = byp_active ? byp_long  : long_q;
  assign instr_valid = byp_active ? byp_valid : valid_q;
  assign instr_pc    = pc_q;
  assign byp_pop     = byp_active & byp_valid & instr_ready;
`else
  assign instr       = instr_q;
  assign instr_long  = long_q;
  assign instr_valid = valid_q;
  assign instr_pc    = pc_q;
  assign byp_pop     = 1'b0;
`endif

  always_comb begin
    pop      = instr_valid & instr_ready & ~flush;
    pop_len  = instr_long ? 2'd2 : 2'd1;
    push_eff = push & ~byp_pop;
    q_pop    = '0;
    if (pop) q_pop = OW'(pop_len) - OW'(byp_pop);
    occ_n    = occ + OW'(push_eff) - q_pop;
    rd_n     = rd_ptr + AW'(q_pop);
    rd1_n    = rd_n + AW'(1);
    wr_n     = wr_ptr + AW'(push_eff);
    // Head view after this cycle's push/pop, used to register the decoder outputs.
    w0_n     = (push_eff && (wr_ptr == rd_n))  ? imem_data : mem[rd_n];
    w1_n     = (push_eff && (wr_ptr == rd1_n)) ? imem_data : mem[rd1_n];
    valid_n  = (occ_n != '0) & (~w0_n[15] | (occ_n >= OW'(2)));
    head_pc_n = pop ? head_pc + 20'(pop_len) : head_pc;
  end

  always_ff @(posedge clock) begin
    if (push_eff) mem[wr_ptr] <= imem_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      fetch_pc <= RESET_PC;
      head_pc  <= RESET_PC;
      inflight <= 1'b0;
      kill     <= 1'b0;
      instr_q  <= '0;
      pc_q     <= RESET_PC;
      long_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      inflight <= imem_req;
      kill     <= flush;
      if (flush) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        occ      <= '0;
        fetch_pc <= flush_pc;
        head_pc  <= flush_pc;
        pc_q     <= flush_pc;
        instr_q  <= '0;
        long_q   <= 1'b0;
        valid_q  <= 1'b0;
      end else begin
        if (imem_req) fetch_pc <= fetch_pc + 20'd1;
        rd_ptr  <= rd_n;
        wr_ptr  <= wr_n;
        occ     <= occ_n;
        head_pc <= head_pc_n;
        pc_q    <= head_pc_n;
        valid_q <= valid_n;
        long_q  <= w0_n[15];
        instr_q <= w0_n[15] ? {w1_n, w0_n} : {16'h0000, w0_n};
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, corner-case sequences and randomized traffic
// checked against an instruction-stream model derived from the memory image.
module tb_fetch_queue;
  localparam int DEPTH = 8;
  localparam int W     = 53;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 3;
`endif

  logic        clock = 1'b0, reset = 1'b0, stop = 1'b0, flush = 1'b0, instr_ready = 1'b0;
  logic [19:0] flush_pc = '0;
  logic [15:0] imem_data = '0;
  logic [19:0] imem_addr, instr_pc;
  logic        imem_req, instr_long, instr_valid;
  logic [31:0] instr;
  logic [$clog2(DEPTH):0] occupancy;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(20'h00000)) dut (
    .clock(clock), .reset(reset), .stop(stop), .flush(flush), .flush_pc(flush_pc),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_data(imem_data),
    .instr(instr), .instr_pc(instr_pc), .instr_long(instr_long), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  int vectors = 0, miscompares = 0, pops = 0;
  logic [15:0] img [logic [19:0]];
  logic [W-1:0] exp_q[$];
  logic [19:0] gen_pc, fetch_model;

  function automatic logic [15:0] img_word(input logic [19:0] a);
    if (img.exists(a)) return img[a];
    return 16'(a * 20'd40503) ^ 16'h5a5a;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference stream: walk the image from the current pc, one instruction at a time.
  function automatic void refill();
    logic [15:0] a0, a1;
    while (exp_q.size() < 8) begin
      a0 = img_word(gen_pc);
      if (a0[15]) begin
        a1 = img_word(gen_pc + 20'd1);
        exp_q.push_back({gen_pc, 1'b1, a1, a0});
        gen_pc = gen_pc + 20'd2;
      end else begin
        exp_q.push_back({gen_pc, 1'b0, 16'h0000, a0});
        gen_pc = gen_pc + 20'd1;
      end
    end
  endfunction

  // Instruction memory: data one cycle after the request, junk otherwise.
  initial begin
    logic        r;
    logic [15:0] d;
    forever begin
      @(negedge clock);
      r = imem_req;
      d = img_word(imem_addr);
      @(posedge clock);
      #1;
      imem_data = r ? d : 16'($urandom);
    end
  end

  // Scoreboard / monitor.
  initial begin
    logic [W-1:0] e;
    logic         hold_prev = 1'b0;
    logic [63:0]  prev_out = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        exp_q.delete();
        gen_pc      = 20'h00000;
        fetch_model = 20'h00000;
        hold_prev   = 1'b0;
      end else begin
        check("occ_bound", 64'(occupancy <= DEPTH), 64'd1);
        if (hold_prev) check("hold_stable", {10'd0, instr_valid, instr_long, instr_pc, instr}, prev_out);
        if (flush) begin
          exp_q.delete();
          gen_pc      = flush_pc;
          fetch_model = flush_pc;
        end else begin
          if (imem_req) begin
            check("imem_addr", 64'(imem_addr), 64'(fetch_model));
            fetch_model = fetch_model + 20'd1;
          end
          if (instr_valid && instr_ready) begin
            refill();
            e = exp_q.pop_front();
            check("sb_instr", 64'(instr), 64'(e[31:0]));
            check("sb_pc", 64'(instr_pc), 64'(e[52:33]));
            check("sb_long", 64'(instr_long), 64'(e[32]));
            pops++;
          end
        end
        hold_prev = instr_valid && !instr_ready && !flush;
        prev_out  = {10'd0, instr_valid, instr_long, instr_pc, instr};
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_flush(input logic [19:0] pc);
    flush    = 1'b1;
    flush_pc = pc;
    tick(1);
    flush = 1'b0;
  endtask

  task automatic wait_valid(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (instr_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [19:0] pc;
    logic [15:0] w0, w1, w2;
    logic [31:0] exp_instr;
    logic        exp_long;
    logic [19:0] exp_next_pc;
    logic [31:0] exp_next_instr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic ok;
    int   k, p0;
    vecs[0] = '{20'h00000, 16'h0123, 16'h0456, 16'h0789, 32'h00000123, 1'b0, 20'h00001, 32'h00000456};
    vecs[1] = '{20'h00020, 16'h8001, 16'h1234, 16'h0042, 32'h12348001, 1'b1, 20'h00022, 32'h00000042};
    vecs[2] = '{20'hFFFFF, 16'h8abc, 16'h5678, 16'h0011, 32'h56788abc, 1'b1, 20'h00001, 32'h00000011};
    vecs[3] = '{20'h00100, 16'h7fff, 16'h8000, 16'h0001, 32'h00007fff, 1'b0, 20'h00101, 32'h00018000};
    vecs[4] = '{20'h00040, 16'hffff, 16'h0000, 16'h1111, 32'h0000ffff, 1'b1, 20'h00042, 32'h00001111};

    // Reset state.
    img[20'h00000] = vecs[0].w0;
    img[20'h00001] = vecs[0].w1;
    img[20'h00002] = vecs[0].w2;
    repeat (3) @(negedge clock);
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'h0);
    check("rst_instr", 64'(instr), 64'h0);
    check("rst_pc", 64'(instr_pc), 64'h0);
    check("rst_long", 64'(instr_long), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_occ", 64'(occupancy), 64'd0);
    tick(1);
    reset = 1'b1;

    // Vector table; entry 0 comes straight out of reset.
    for (int i = 0; i < 5; i++) begin
      instr_ready = 1'b0;
      if (i != 0) begin
        img[vecs[i].pc]          = vecs[i].w0;
        img[vecs[i].pc + 20'd1]  = vecs[i].w1;
        img[vecs[i].pc + 20'd2]  = vecs[i].w2;
        do_flush(vecs[i].pc);
      end
      wait_valid(ok);
      check("vec_valid", 64'(ok), 64'd1);
      check("vec_instr", 64'(instr), 64'(vecs[i].exp_instr));
      check("vec_pc", 64'(instr_pc), 64'(vecs[i].pc));
      check("vec_long", 64'(instr_long), 64'(vecs[i].exp_long));
      tick(1);
      instr_ready = 1'b1;
      tick(1);
      instr_ready = 1'b0;
      wait_valid(ok);
      check("vec_next_valid", 64'(ok), 64'd1);
      check("vec_next_pc", 64'(instr_pc), 64'(vecs[i].exp_next_pc));
      check("vec_next_instr", 64'(instr), 64'(vecs[i].exp_next_instr));
      tick(1);
    end

    // Latency from a flush to the first short instruction.
    img[20'h00500] = 16'h0042;
    do_flush(20'h00500);
    k = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (instr_valid) break;
      k++;
    end
    check("latency", 64'(k), 64'(EXP_LAT));
    tick(1);

    // Stop with 3 words queued and 1 in flight.
    for (int i = 0; i < 8; i++) img[20'h00300 + 20'(i)] = 16'h0300 + 16'(i);
    do_flush(20'h00300);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (occupancy == 2) break;
    end
    check("stop_pre_req", 64'(imem_req), 64'd1);
    tick(1);
    stop = 1'b1;
    @(negedge clock);
    check("stop_occ3", 64'(occupancy), 64'd3);
    check("stop_req", 64'(imem_req), 64'd0);
    tick(1);
    instr_ready = 1'b1;
    p0 = pops;
    tick(8);
    check("stop_pops", 64'(pops - p0), 64'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("stop_empty", 64'(occupancy), 64'd0);
      check("stop_noreq", 64'(imem_req), 64'd0);
    end
    tick(1);
    stop = 1'b0;
    instr_ready = 1'b0;

    // Backpressure until the queue saturates, then drain in order.
    do_flush(20'h00200);
    tick(20);
    @(negedge clock);
    check("full_occ", 64'(occupancy), 64'(DEPTH));
    check("full_req", 64'(imem_req), 64'd0);
    tick(1);
    instr_ready = 1'b1;
    tick(20);

    // Flush while a response is in flight.
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (imem_req) break;
    end
    tick(1);
    flush    = 1'b1;
    flush_pc = 20'h00100;
    @(negedge clock);
    check("flush_noreq", 64'(imem_req), 64'd0);
    tick(1);
    flush = 1'b0;
    @(negedge clock);
    check("flush_addr", 64'(imem_addr), 64'h00100);
    check("flush_req", 64'(imem_req), 64'd1);
    wait_valid(ok);
    check("flush_first_pc", 64'(instr_pc), 64'h00100);
    tick(1);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      stop        = ($urandom_range(0, 15) == 0);
      flush       = ($urandom_range(0, 40) == 0);
      flush_pc    = ($urandom_range(0, 3) == 0) ? 20'hFFFFD : 20'($urandom);
      tick(1);
    end
    flush = 1'b0;
    stop = 1'b0;
    instr_ready = 1'b1;
    tick(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
